// File: rtl/inst_mem_loader.sv
// Boot-time program loader: turns a UART byte stream (word count N, then N
// little-endian words) into write pulses on the instruction memory port.
module inst_mem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift_reg;
  logic [ADDR_W:0]   word_total;
  logic              accept;
  logic              word_done;
  logic [31:0]       word;

  // The fourth byte is used straight off the bus, so only three are stored.
  assign rx_ready  = (state == LEN) || (state == DATA);
  assign busy      = (state == LEN) || (state == DATA);
  assign accept    = rx_valid && rx_ready;
  assign word_done = accept && (byte_cnt == 2'd3);
  assign word      = {rx_data, shift_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      shift_reg    <= 24'd0;
      word_total   <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= 32'd0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    shift_reg[7:0]   <= rx_data;
          2'd1:    shift_reg[15:8]  <= rx_data;
          2'd2:    shift_reg[23:16] <= rx_data;
          default: ;
        endcase
      end
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= 2'd0;
          end else if (state == DONE) begin
            // Covers the final data write, whose done follows one cycle later.
            done <= 1'b1;
          end
        end
        LEN: begin
          if (word_done) begin
            if (word == 32'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (word > 32'(MAX_WORDS)) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              word_total <= word[ADDR_W:0];
              state      <= DATA;
            end
          end
        end
        DATA: begin
          if (word_done) begin
            mem_we       <= 1'b1;
            mem_wdata    <= word;
            mem_waddr    <= BASE_A + words_loaded[ADDR_W-1:0];
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
            if (words_loaded + (ADDR_W+1)'(1) == word_total)
              state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: two instances (base 0 and base 1022) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;

  logic        rxReady0, we0, busy0, done0, err0;
  logic [9:0]  waddr0;
  logic [31:0] wdata0;
  logic [10:0] wl0;
  logic        rxReady1, we1, busy1, done1, err1;
  logic [9:0]  waddr1;
  logic [31:0] wdata1;
  logic [10:0] wl1;

  inst_mem_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(1024)) dut0 (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rxReady0), .mem_we(we0), .mem_waddr(waddr0), .mem_wdata(wdata0),
    .busy(busy0), .done(done0), .err(err0), .words_loaded(wl0));

  inst_mem_loader #(.ADDR_W(10), .BASE_ADDR(1022), .MAX_WORDS(1024)) dut1 (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rxReady1), .mem_we(we1), .mem_waddr(waddr1), .mem_wdata(wdata1),
    .busy(busy1), .done(done1), .err(err1), .words_loaded(wl1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: parses the stream as the bench sends it and predicts writes and levels.
  typedef struct {int a0; int a1; logic [31:0] d; int due;} exp_t;
  exp_t        q[$];
  logic        mActive = 1'b0, mDoneNow = 1'b0, mErr = 1'b0, mHdr = 1'b1;
  int          mDoneAt = -1, mWl = 0, mK = 0, mN = 0, mIdx = 0;
  logic [31:0] mAcc = 32'd0;

  task automatic modelReset();
    q.delete();
    mActive = 1'b0; mDoneNow = 1'b0; mErr = 1'b0; mHdr = 1'b1;
    mDoneAt = -1; mWl = 0; mK = 0; mN = 0; mIdx = 0; mAcc = 32'd0;
  endtask

  task automatic modelStart();
    modelReset();
    mActive = 1'b1;
  endtask

  task automatic modelByte(input logic [7:0] b);
    exp_t e;
    mAcc[8*mK +: 8] = b;
    mK++;
    if (mK == 4) begin
      mK = 0;
      if (mHdr) begin
        if (mAcc == 32'd0) begin
          mDoneNow = 1'b1; mActive = 1'b0;
        end else if (mAcc > 32'd1024) begin
          mErr = 1'b1; mActive = 1'b0;
        end else begin
          mN = int'(mAcc); mHdr = 1'b0;
        end
      end else begin
        e.a0 = mIdx % 1024;
        e.a1 = (1022 + mIdx) % 1024;
        e.d = mAcc;
        e.due = cyc;
        q.push_back(e);
        mIdx++;
        mWl = mIdx;
        if (mIdx == mN) begin
          mActive = 1'b0;
          mDoneAt = cyc + 1;
        end
      end
      mAcc = 32'd0;
    end
  endtask

  int          log0Addr[$], log1Addr[$];
  logic [31:0] log0Data[$];
  logic        wantWe, expDone;

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (we0) begin log0Addr.push_back(int'(waddr0)); log0Data.push_back(wdata0); end
    if (we1) log1Addr.push_back(int'(waddr1));
    wantWe  = (q.size() > 0) && (q[0].due == cyc);
    expDone = mDoneNow || (mDoneAt >= 0 && cyc >= mDoneAt);
    checkOutput("we0", 32'(we0), 32'(wantWe));
    checkOutput("we1", 32'(we1), 32'(wantWe));
    if (wantWe) begin
      checkOutput("waddr0", 32'(waddr0), 32'(q[0].a0));
      checkOutput("waddr1", 32'(waddr1), 32'(q[0].a1));
      checkOutput("wdata0", wdata0, q[0].d);
      checkOutput("wdata1", wdata1, q[0].d);
      void'(q.pop_front());
    end
    checkOutput("rxReady0", 32'(rxReady0), 32'(mActive));
    checkOutput("rxReady1", 32'(rxReady1), 32'(mActive));
    checkOutput("busy0", 32'(busy0), 32'(mActive));
    checkOutput("done0", 32'(done0), 32'(expDone));
    checkOutput("done1", 32'(done1), 32'(expDone));
    checkOutput("err0", 32'(err0), 32'(mErr));
    checkOutput("err1", 32'(err1), 32'(mErr));
    checkOutput("wl0", 32'(wl0), 32'(mWl));
    checkOutput("wl1", 32'(wl1), 32'(mWl));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one byte for a cycle, then leaves rx_valid low for gap cycles.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    logic willAccept;
    willAccept = mActive;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    if (willAccept) modelByte(b);
    rx_valid = 1'b0;
    if (gap > 0) idle(gap);
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], gap);
  endtask

  task automatic startLoad();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    modelStart();
    log0Addr.delete(); log0Data.delete(); log1Addr.delete();
  endtask

  task automatic nominalLoad(input int gap);
    startLoad();
    sendWord(32'd2, gap);
    sendWord(32'h13, gap);
    sendWord(32'h6F, gap);
    idle(3);
    checkOutput("nomCount", 32'(log0Addr.size()), 32'd2);
    if (log0Addr.size() == 2) begin
      checkOutput("nomAddrA", 32'(log0Addr[0]), 32'd0);
      checkOutput("nomAddrB", 32'(log0Addr[1]), 32'd1);
      checkOutput("nomDataA", log0Data[0], 32'h0000_0013);
      checkOutput("nomDataB", log0Data[1], 32'h0000_006F);
    end
    checkOutput("nomDone", 32'(done0), 32'd1);
    checkOutput("nomWl", 32'(wl0), 32'd2);
    checkOutput("nomBusy", 32'(busy0), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    modelReset();
    idle(2);
    checkOutput("rstReady", 32'(rxReady0), 32'd0);
    checkOutput("rstWe", 32'(we0), 32'd0);
    checkOutput("rstAddr", 32'(waddr0), 32'd0);
    checkOutput("rstData", wdata0, 32'd0);
    checkOutput("rstFlags", {29'd0, busy0, done0, err0}, 32'd0);
    checkOutput("rstWl", 32'(wl0), 32'd0);
    rst = 1'b0;
    idle(2);

    $display("[TB] nominal load");
    nominalLoad(0);

    $display("[TB] load with gaps and an ignored start");
    startLoad();
    sendWord(32'd2, 3);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    sendWord(32'h13, 3);
    sendWord(32'h6F, 3);
    idle(3);
    checkOutput("gapCount", 32'(log0Addr.size()), 32'd2);
    checkOutput("gapWl", 32'(wl0), 32'd2);
    checkOutput("gapDone", 32'(done0), 32'd1);

    $display("[TB] zero length");
    startLoad();
    sendWord(32'd0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) applyStimulus(8'hA5, 0);
    idle(2);
    checkOutput("zeroDone", 32'(done0), 32'd1);
    checkOutput("zeroErr", 32'(err0), 32'd0);
    checkOutput("zeroReady", 32'(rxReady0), 32'd0);
    checkOutput("zeroWrites", 32'(log0Addr.size()), 32'd0);

    $display("[TB] over length");
    startLoad();
    sendWord(32'd1025, 0);
    idle(2);
    checkOutput("overErr", 32'(err0), 32'd1);
    checkOutput("overDone", 32'(done0), 32'd0);
    checkOutput("overWrites", 32'(log0Addr.size()), 32'd0);
    startLoad();
    checkOutput("overRestartErr", 32'(err0), 32'd0);
    checkOutput("overRestartBusy", 32'(busy0), 32'd1);
    sendWord(32'd0, 1);
    idle(2);

    $display("[TB] wrap-around");
    startLoad();
    sendWord(32'd4, 0);
    sendWord(32'hDEAD_BEEF, 0);
    sendWord(32'h0000_0001, 1);
    sendWord(32'h8000_0000, 0);
    sendWord(32'h1234_5678, 2);
    idle(3);
    checkOutput("wrapCount", 32'(log1Addr.size()), 32'd4);
    if (log1Addr.size() == 4) begin
      checkOutput("wrapAddr0", 32'(log1Addr[0]), 32'd1022);
      checkOutput("wrapAddr1", 32'(log1Addr[1]), 32'd1023);
      checkOutput("wrapAddr2", 32'(log1Addr[2]), 32'd0);
      checkOutput("wrapAddr3", 32'(log1Addr[3]), 32'd1);
    end
    checkOutput("wrapWl", 32'(wl1), 32'd4);

    $display("[TB] reset mid-load");
    startLoad();
    sendWord(32'd3, 0);
    sendWord(32'hCAFE_0001, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midRstWe", 32'(we0), 32'd0);
    checkOutput("midRstAddr", 32'(waddr0), 32'd0);
    checkOutput("midRstData", wdata0, 32'd0);
    checkOutput("midRstFlags", {28'd0, rxReady0, busy0, done0, err0}, 32'd0);
    checkOutput("midRstWl", 32'(wl0), 32'd0);
    log0Addr.delete(); log0Data.delete(); log1Addr.delete();
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 2);
    checkOutput("midRstNoWrite", 32'(log0Addr.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    nominalLoad(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time program loader that sequences the write port of the 1024x32 distributed instruction memory.
- Accepts a byte stream from the UART receiver through a valid/ready handshake.
- Stream format: a 32-bit little-endian word count N, then N little-endian 32-bit instruction words.
- Writes word i to instruction memory at BASE_ADDR+i, then reports completion so the core can be released from reset.

Parameters:
- ADDR_W, 10, instruction memory address width; addresses wrap modulo 2^ADDR_W.
- BASE_ADDR, 0, address written by the first data word.
- MAX_WORDS, 1024, largest legal N; N > MAX_WORDS is a format error.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE and ERR.
- rx_valid  input  1  byte available from the UART receiver.
- rx_data  input  8  received byte.
- rx_ready  output  1  loader accepts the byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_waddr  output  ADDR_W  instruction memory write address.
- mem_wdata  output  32  instruction memory write data.
- busy  output  1  high in LEN and DATA.
- done  output  1  load completed successfully; level signal.
- err  output  1  length error; level signal.
- words_loaded  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset values: every output is 0, state is IDLE, and all counters and the byte shift register are 0. Reset mid-load aborts the load immediately and no further mem_we pulse is issued.
- States: IDLE, LEN, DATA, DONE, ERR.
- start in IDLE, DONE or ERR: go to LEN and clear done, err, words_loaded and byte_cnt. start in LEN or DATA is ignored.
- Byte handshake: a byte is accepted when rx_valid && rx_ready. rx_ready = 1 only in LEN and DATA, so rx_valid is ignored in all other states. Bytes are accepted at up to one per cycle, and gaps in rx_valid are allowed.
- Word assembly: a 2-bit byte_cnt counts accepted bytes. The byte accepted at byte_cnt = k goes to bits [8k+7:8k]. The 4th byte completes the word and byte_cnt wraps to 0.
- LEN state, on word completion with N = assembled word:
  - N == 0: go to DONE; done = 1 next cycle; no writes.
  - N > MAX_WORDS: go to ERR; err = 1 next cycle; no writes.
  - Otherwise latch N and go to DATA.
- DATA state, on word completion:
  - Next cycle: mem_we = 1 for exactly one cycle, mem_wdata = assembled word, mem_waddr = (BASE_ADDR + words_loaded) mod 2^ADDR_W. words_loaded increments in that same cycle.
  - Latency from the 4th byte handshake to the mem_we pulse is 1 cycle.
  - mem_waddr and mem_wdata are registered and hold their last values when mem_we = 0.
- A byte accepted in the cycle mem_we is high is legal and is assembled normally; there is no stall.
- When the write of word N-1 issues, rx_ready drops in that same cycle, the state goes to DONE, and done = 1 one cycle after the final mem_we.
- done and err are levels held until the next start or reset. done and err are never both 1.
- words_loaded is ADDR_W+1 bits wide so that it can hold MAX_WORDS = 1024 without overflow.

Test Plan:
- Nominal load: start, then bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 back-to-back -> mem_we pulses at addresses 0 and 1 with data 0x00000013 and 0x0000006F; done = 1; words_loaded = 2; busy = 0.
- Backpressure gaps: same stream as the nominal load with rx_valid low for 3 cycles between every byte -> identical writes; each mem_we exactly 1 cycle after its 4th byte.
- Zero length: stream 00 00 00 00 -> no mem_we; done = 1; err = 0; rx_ready = 0 afterwards; further rx_valid is ignored.
- Over length: stream 01 04 00 00 (N = 1025) -> err = 1; done = 0; no mem_we; a following start returns to LEN with err cleared.
- Wrap-around: BASE_ADDR = 1022 and N = 4 -> writes to addresses 1022, 1023, 0, 1 in order; words_loaded = 4.
- Reset mid-load: assert rst after the 2nd byte of data word 1 in a 3-word load -> all outputs 0 asynchronously; no mem_we after reset; a new start loads correctly from BASE_ADDR.
